// File: rtl/corr_readout_seq_if.sv
// corr_readout_seq_if
//   Bus bundle between the readout sequencer, the bank-select RAM mux and the
//   downstream stream sink.
//
//   Signals
//     ram_addr  [15:0] sequencer -> RAM mux; [15:12] bank, [11:0] word index
//     ram_data  [31:0] RAM mux -> sequencer; valid one clk after ram_addr changes
//     out_data  [31:0] stream word
//     out_valid        out_data is valid
//     out_ready        sink accepts out_data
//     out_last         final word of the readout
//
//   Stream handshake: a word moves on every rising clk edge where
//   out_valid && out_ready are both high. Once out_valid is raised, out_data,
//   out_valid and out_last stay unchanged until that transfer edge. out_valid
//   never waits on out_ready, and out_ready may change freely at any time.
//
//   Modports
//     master : the sequencer side
//     slave  : the RAM mux / sink side
interface corr_readout_seq_if;
  logic [15:0] ram_addr;
  logic [31:0] ram_data;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  modport master (
    output ram_addr,
    input  ram_data,
    output out_data,
    output out_valid,
    input  out_ready,
    output out_last
  );

  modport slave (
    input  ram_addr,
    output ram_data,
    input  out_data,
    input  out_valid,
    output out_ready,
    input  out_last
  );
endinterface

// File: rtl/corr_readout_seq.sv
// corr_readout_seq
//   Reads every correlator bank out through the bank-select RAM mux and
//   streams the words to a valid/ready sink. Bank k is at 0xk000 and holds
//   BASE_LEN<<(k-1) words. The correlators are frozen for the whole readout.
//
//   Parameters
//     NUM_BANKS  number of banks (1..15)
//     BASE_LEN   word count of bank 1 (the largest bank must fit in 12 bits)
//
//   Ports
//     clk       rising-edge clock
//     rst       synchronous active-high reset
//     start     one-cycle readout request, honoured only when idle
//     busy      high from start acceptance until the done cycle
//     freeze    correlator hold, same timing as busy
//     done      one-cycle pulse when the readout completes
//     dbgState  current FSM state encoding
//     bus       RAM address/data and output stream (master side)
//
//   Build option
//     CORR_FRAME_HDR_EN  when defined, every bank is preceded by a header word
//                        {16'hC0DE, bank[3:0], length[11:0]}.
module corr_readout_seq #(
  parameter int NUM_BANKS = 5,
  parameter int BASE_LEN  = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       freeze,
  output logic       done,
  output logic [2:0] dbgState,
  corr_readout_seq_if.master bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
`ifdef CORR_FRAME_HDR_EN
    HDR  = 3'd1,
`endif
    RD   = 3'd2,
    CAP  = 3'd3,
    OUT  = 3'd4,
    FIN  = 3'd5
  } state_t;

  localparam logic [3:0]  LAST_BANK = 4'(NUM_BANKS);
  localparam logic [15:0] FIRST_LEN = 16'(BASE_LEN);

  state_t      state;
  logic [3:0]  bank;
  logic [11:0] idx;
  logic [15:0] bankLen;   // word count of the current bank

  logic        lastInBank;
  logic [3:0]  nextBank;
  logic [15:0] nextLen;

  assign lastInBank = ({4'h0, idx} == bankLen - 16'd1);
  assign nextBank   = bank + 4'd1;
  assign nextLen    = bankLen << 1;
  assign dbgState   = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      busy          <= 1'b0;
      freeze        <= 1'b0;
      done          <= 1'b0;
      bank          <= 4'd0;
      idx           <= 12'd0;
      bankLen       <= 16'd0;
      bus.ram_addr  <= 16'h0000;
      bus.out_data  <= 32'd0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy         <= 1'b1;
            freeze       <= 1'b1;
            bank         <= 4'd1;
            idx          <= 12'd0;
            bankLen      <= FIRST_LEN;
            bus.ram_addr <= 16'h1000;
`ifdef CORR_FRAME_HDR_EN
            bus.out_data  <= {16'hC0DE, 4'd1, FIRST_LEN[11:0]};
            bus.out_valid <= 1'b1;
            state         <= HDR;
`else
            state         <= RD;
`endif
          end
        end

`ifdef CORR_FRAME_HDR_EN
        // The address was already set on bank entry, so the RAM read for
        // word 0 overlaps the header transfer.
        HDR: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= RD;
          end
        end
`endif

        // One idle cycle covers the RAM read latency.
        RD: state <= CAP;

        CAP: begin
          bus.out_data  <= bus.ram_data;
          bus.out_valid <= 1'b1;
          bus.out_last  <= lastInBank && (bank == LAST_BANK);
          state         <= OUT;
        end

        OUT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            if (!lastInBank) begin
              idx          <= idx + 12'd1;
              bus.ram_addr <= {bank, idx + 12'd1};
              state        <= RD;
            end else if (bank == LAST_BANK) begin
              // Address stays on the final word until FIN clears it.
              done  <= 1'b1;
              state <= FIN;
            end else begin
              bank         <= nextBank;
              idx          <= 12'd0;
              bankLen      <= nextLen;
              bus.ram_addr <= {nextBank, 12'h000};
`ifdef CORR_FRAME_HDR_EN
              bus.out_data  <= {16'hC0DE, nextBank, nextLen[11:0]};
              bus.out_valid <= 1'b1;
              state         <= HDR;
`else
              state         <= RD;
`endif
            end
          end
        end

        FIN: begin
          done         <= 1'b0;
          busy         <= 1'b0;
          freeze       <= 1'b0;
          bus.ram_addr <= 16'h0000;
          state        <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_corr_readout_seq.sv
`timescale 1ns/1ps
module tb_corr_readout_seq;

  localparam int NB = 5;
  localparam int BL = 32;
`ifdef CORR_FRAME_HDR_EN
  localparam int HDR_WORDS = 1;
`else
  localparam int HDR_WORDS = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // main instance (default geometry)
  logic       start, busy, freeze, done;
  logic [2:0] dbgState;
  corr_readout_seq_if bus();

  corr_readout_seq #(.NUM_BANKS(NB), .BASE_LEN(BL)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .freeze(freeze),
    .done(done), .dbgState(dbgState), .bus(bus)
  );

  // small instance: one bank of four words
  logic       startS, busyS, freezeS, doneS;
  logic [2:0] dbgStateS;
  corr_readout_seq_if busS();

  corr_readout_seq #(.NUM_BANKS(1), .BASE_LEN(4)) dutS (
    .clk(clk), .rst(rst), .start(startS), .busy(busyS), .freeze(freezeS),
    .done(doneS), .dbgState(dbgStateS), .bus(busS)
  );

  // RAM mux model: each location reads back its own address, one clk late
  always @(posedge clk) begin
    bus.ram_data  <= {16'h0000, bus.ram_addr};
    busS.ram_data <= {16'h0000, busS.ram_addr};
  end

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic        gotLast_q[$];
  int          stallErr, doneCnt, doneCyc, lastXferCyc, firstXferCyc;
  bit          timedOut;
  logic        busyAfter;

  // Reference: every bank in order, optional header, then addresses k000..
  function automatic void build_expected(input int nb, input int bl);
    exp_q.delete();
    for (int b = 1; b <= nb; b++) begin
      int len;
      len = bl << (b - 1);
`ifdef CORR_FRAME_HDR_EN
      exp_q.push_back({16'hC0DE, 4'(b), 12'(len)});
`endif
      for (int i = 0; i < len; i++) exp_q.push_back(32'((b << 12) + i));
    end
  endfunction

  // ---------------- driver / monitor ----------------
  // Called on a negedge; returns on a negedge. Records every transfer and
  // the done pulse; stops at stopAt transfers or a few cycles after done.
  task automatic collect(input int readyPct, input bit doStart,
                         input int startAgainAt, input int stopAt);
    bit          prevStall = 1'b0;
    logic [31:0] prevData  = '0;
    logic        prevLast  = 1'b0;
    bit          pulsed    = 1'b0;
    got_q.delete();
    gotLast_q.delete();
    stallErr = 0; doneCnt = 0; doneCyc = -1;
    lastXferCyc = -1; firstXferCyc = -1; timedOut = 1'b0; busyAfter = 1'bx;
    if (doStart) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int cyc = 0; cyc < 20000; cyc++) begin
      start = 1'b0;
      bus.out_ready = ($urandom_range(99) < readyPct);
      if (prevStall && (bus.out_valid !== 1'b1 || bus.out_data !== prevData ||
                        bus.out_last !== prevLast))
        stallErr++;
      if (done === 1'b1) begin
        doneCnt++;
        if (doneCyc < 0) doneCyc = cyc;
      end
      if (doneCyc >= 0 && cyc == doneCyc + 1) busyAfter = busy;
      if (bus.out_valid === 1'b1 && bus.out_ready) begin
        got_q.push_back(bus.out_data);
        gotLast_q.push_back(bus.out_last);
        if (firstXferCyc < 0) firstXferCyc = cyc;
        lastXferCyc = cyc;
      end
      prevStall = (bus.out_valid === 1'b1) && !bus.out_ready;
      prevData  = bus.out_data;
      prevLast  = bus.out_last;
      if (!pulsed && startAgainAt >= 0 && got_q.size() == startAgainAt) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end
      if (stopAt >= 0 && got_q.size() == stopAt) return;
      if (doneCyc >= 0 && cyc >= doneCyc + 3) return;
      @(negedge clk);
    end
    timedOut = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; startS = 1'b0;
    bus.out_ready = 1'b0; busS.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (freeze !== 1'b0) begin failures++; $display("FAIL reset_freeze got=%b exp=0", freeze); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_last !== 1'b0) begin failures++; $display("FAIL reset_last got=%b exp=0", bus.out_last); end
    checks++; if (bus.out_data !== 32'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", bus.out_data); end
    checks++; if (bus.ram_addr !== 16'h0000) begin failures++; $display("FAIL reset_addr got=%h exp=0000", bus.ram_addr); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_rate();
    int expCount;
    expCount = BL * ((1 << NB) - 1) + NB * HDR_WORDS;
    build_expected(NB, BL);
    collect(100, 1'b1, -1, -1);
    checks++; if (timedOut) begin failures++; $display("FAIL full_timeout got=timeout exp=done"); end
    checks++; if (got_q.size() != expCount) begin failures++; $display("FAIL full_count got=%0d exp=%0d", got_q.size(), expCount); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL full_word[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
      checks++; if (gotLast_q[i] !== (i == exp_q.size() - 1)) begin failures++; $display("FAIL full_last[%0d] got=%b exp=%b", i, gotLast_q[i], (i == exp_q.size() - 1)); end
    end
    checks++; if (doneCnt != 1) begin failures++; $display("FAIL full_done_count got=%0d exp=1", doneCnt); end
    checks++; if (doneCyc != lastXferCyc + 1) begin failures++; $display("FAIL full_done_timing got=%0d exp=%0d", doneCyc, lastXferCyc + 1); end
    checks++; if (busyAfter !== 1'b0) begin failures++; $display("FAIL full_busy_after got=%b exp=0", busyAfter); end
`ifndef CORR_FRAME_HDR_EN
    checks++; if (lastXferCyc - firstXferCyc != 3 * (expCount - 1)) begin failures++; $display("FAIL full_throughput got=%0d exp=%0d", lastXferCyc - firstXferCyc, 3 * (expCount - 1)); end
`endif
  endtask

  task automatic test_random_ready();
    build_expected(NB, BL);
    collect(30, 1'b1, -1, -1);
    checks++; if (timedOut) begin failures++; $display("FAIL rand_timeout got=timeout exp=done"); end
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand_word[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
      checks++; if (gotLast_q[i] !== (i == exp_q.size() - 1)) begin failures++; $display("FAIL rand_last[%0d] got=%b exp=%b", i, gotLast_q[i], (i == exp_q.size() - 1)); end
    end
    checks++; if (stallErr != 0) begin failures++; $display("FAIL rand_stall_stable got=%0d exp=0", stallErr); end
    checks++; if (doneCnt != 1) begin failures++; $display("FAIL rand_done_count got=%0d exp=1", doneCnt); end
  endtask

  task automatic test_start_ignored();
    build_expected(NB, BL);
    collect(100, 1'b1, 100, -1);
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL restart_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL restart_word[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (doneCnt != 1) begin failures++; $display("FAIL restart_done_count got=%0d exp=1", doneCnt); end
  endtask

  task automatic test_midrun_reset();
    build_expected(NB, BL);
    collect(50, 1'b1, -1, 500);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (freeze !== 1'b0) begin failures++; $display("FAIL abort_freeze got=%b exp=0", freeze); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL abort_done got=%b exp=0", done); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL abort_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.ram_addr !== 16'h0000) begin failures++; $display("FAIL abort_addr got=%h exp=0000", bus.ram_addr); end
    checks++; if (bus.out_data !== 32'd0) begin failures++; $display("FAIL abort_data got=%h exp=0", bus.out_data); end
    rst = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rerun_busy got=%b exp=1", busy); end
    checks++; if (bus.ram_addr !== 16'h1000) begin failures++; $display("FAIL rerun_addr got=%h exp=1000", bus.ram_addr); end
    collect(100, 1'b0, -1, -1);
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL rerun_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rerun_word[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (doneCnt != 1) begin failures++; $display("FAIL rerun_done_count got=%0d exp=1", doneCnt); end
  endtask

  task automatic test_single_bank();
    build_expected(1, 4);
    got_q.delete();
    gotLast_q.delete();
    doneCyc = -1; lastXferCyc = -1;
    busS.out_ready = 1'b1;
    startS = 1'b1;
    @(negedge clk);
    startS = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (busS.out_valid === 1'b1 && busS.out_ready) begin
        got_q.push_back(busS.out_data);
        gotLast_q.push_back(busS.out_last);
        lastXferCyc = c;
      end
      if (doneS === 1'b1 && doneCyc < 0) doneCyc = c;
      if (doneCyc >= 0) break;
      @(negedge clk);
    end
    checks++; if (got_q.size() != 4 + HDR_WORDS) begin failures++; $display("FAIL small_count got=%0d exp=%0d", got_q.size(), 4 + HDR_WORDS); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL small_word[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
      checks++; if (gotLast_q[i] !== (i == exp_q.size() - 1)) begin failures++; $display("FAIL small_last[%0d] got=%b exp=%b", i, gotLast_q[i], (i == exp_q.size() - 1)); end
    end
    checks++; if (doneCyc < 0 || doneCyc != lastXferCyc + 1) begin failures++; $display("FAIL small_done_timing got=%0d exp=%0d", doneCyc, lastXferCyc + 1); end
    repeat (2) @(negedge clk);
    checks++; if (busyS !== 1'b0) begin failures++; $display("FAIL small_busy_end got=%b exp=0", busyS); end
  endtask

  // ---------------- sequence + final report ----------------
  initial begin
    test_reset();
    test_full_rate();
    test_random_ready();
    test_start_ignored();
    test_midrun_reset();
    test_single_bank();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/corr_readout_seq.md
CORR_READOUT_SEQ -- requirements
Module: corr_readout_seq

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 5: number of correlator banks, at 0x1000, 0x2000, ... up to 0x5000.
REQ-002 SHALL have parameter BASE_LEN, default 32: word count of bank 1; bank k holds BASE_LEN<<(k-1) words (32/64/128/256/512).
REQ-003 SHALL have port clk, input, 1: single clock; all logic on the rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1: one-cycle request to begin a full readout.
REQ-006 SHALL have port busy, output, 1: high from start acceptance until done.
REQ-007 SHALL have port freeze, output, 1: holds the correlators during readout; same timing as busy.
REQ-008 SHALL have port done, output, 1: one-cycle pulse when the readout completes.
REQ-009 SHALL have port ram_addr, output, 16: address to the bank-select RAM mux; [15:12] is the bank, low bits are the word index.
REQ-010 SHALL have port ram_data, input, 32: read data, valid one clk after ram_addr changes.
REQ-011 SHALL have port out_data, output, 32: stream word.
REQ-012 SHALL have port out_valid, output, 1: out_data is valid.
REQ-013 SHALL have port out_ready, input, 1: the sink accepts out_data.
REQ-014 SHALL have port out_last, output, 1: marks the final word of the readout.

Function
REQ-015 SHALL use the FSM states IDLE, HDR, RD, CAP, OUT, FIN.
REQ-016 IDLE, start=1 SHALL: set busy=freeze=1, bank=1, idx=0, ram_addr=0x1000; next state HDR if the header feature is compiled in, else RD.
REQ-017 start SHALL be ignored in all states except IDLE.
REQ-018 RD SHALL hold ram_addr for one cycle (RAM latency), then go to CAP.
REQ-019 CAP SHALL register ram_data into out_data, set out_valid=1, and go to OUT.
REQ-020 OUT SHALL hold out_data, out_valid and out_last stable until the cycle where out_valid&&out_ready (the transfer).
REQ-021 On a transfer in OUT, out_valid SHALL drop the next cycle.
REQ-022 Transfer, idx < bank length-1: idx+1, ram_addr low bits = idx+1, next state RD.
REQ-023 Transfer, last word of a bank that is not the final bank: bank+1, idx=0, ram_addr={bank+1, 12'h000}, next state HDR or RD (as in REQ-016).
REQ-024 Transfer of the final word of bank NUM_BANKS: next state FIN.
REQ-025 out_last SHALL be 1 exactly while the final word of bank NUM_BANKS is presented in OUT.
REQ-026 FIN SHALL pulse done=1 for one cycle, clear busy and freeze, set ram_addr=0x0000, and return to IDLE.
REQ-027 Throughput SHALL be 1 word per 3 clk with out_ready held high; the total data word count is BASE_LEN*(2^NUM_BANKS-1), i.e. 992 by default.
REQ-028 ram_addr SHALL never exceed the top address of the current bank (no wrap into the next bank's range).
REQ-029 out_ready SHALL be ignored outside OUT (and HDR when compiled in).

Reset
REQ-030 When rst=1 at a clock edge, the block SHALL enter IDLE with busy=freeze=done=out_valid=out_last=0, out_data=0, ram_addr=0x0000, bank=0, idx=0.
REQ-031 rst SHALL take priority over start and over any transfer, including in mid-readout; no done pulse is produced on abort.

Configuration
REQ-032 Macro CORR_FRAME_HDR_EN defined: state HDR presents out_data={16'hC0DE, bank[3:0], length[11:0]} with out_valid=1, out_last=0; on transfer the next state is RD.
REQ-033 CORR_FRAME_HDR_EN undefined: state HDR SHALL not exist, and the stream SHALL contain data words only.

Verification
REQ-034 Reset, then start; ram_data = address echo; out_ready=1 -> 992 words in order 0x1000..0x101F, 0x2000..0x203F, ... 0x51FF; out_last only on 0x51FF; done one cycle after that transfer.
REQ-035 out_ready toggled randomly, 30% duty -> identical word sequence, no drops or duplicates, out_data stable while stalled.
REQ-036 start pulsed again at word 100 -> ignored; count still 992, single done.
REQ-037 rst asserted at word 500, then start -> outputs cleared next cycle; the new readout restarts at 0x1000 with busy=1.
REQ-038 With CORR_FRAME_HDR_EN: 997 words; headers 0xC0DE1020, 0xC0DE2040, 0xC0DE3080, 0xC0DE4100, 0xC0DE5200, each before its bank.
REQ-039 NUM_BANKS=1, BASE_LEN=4 -> 4 words 0x1000..0x1003; out_last on 0x1003; done follows.
